toothless_decode: RTL and testbench

Instruction decode stage of the toothless core: accepts fetched 32-bit instructions over a valid/ready handshake and emits the decoded bundle (ALU opcode, operand selects, register indices, immediate, control flags) that the execute stage and ALU consume. Supports the R, I, S and B opcode classes defined in the core package. A two-entry skid buffer (output register plus skid register) gives one-cycle latency with a fully registered `instr_ready_o`.

---
 rtl/toothless_decode.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_toothless_decode.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/toothless_decode.sv
// Decode stage of the toothless core: R/I/S/B decode into a two-entry skid buffer.
// Optional feature macro: TOOTHLESS_ILLEGAL_KILL_EN (drop illegal instructions, pulse illegal_o).
package toothless_decode_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ALU_W = 5;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned REG_W = 5;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_XOR  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_AND  = 5'd4,
        ALU_SRA  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_GES  = 5'd10,
        ALU_GEU  = 5'd11,
        ALU_EQ   = 5'd12,
        ALU_NE   = 5'd13
    } alu_opcode_e;

    typedef enum logic [SEL_W-1:0] {
        OP_SEL_REG   = 2'b00,
        OP_SEL_CURPC = 2'b01,
        OP_SEL_IMM   = 2'b10
    } op_sel_e;

    typedef struct packed {
        alu_opcode_e      alu_op;
        op_sel_e          a_sel;
        op_sel_e          b_sel;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rd_we;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic             is_branch;
        logic             is_store;
        logic             illegal;
    } dec_bundle_t;
endpackage

module toothless_decode
    import toothless_decode_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [ALU_W-1:0] alu_op_o,
    output logic [SEL_W-1:0] op_a_sel_o,
    output logic [SEL_W-1:0] op_b_sel_o,
    output logic [REG_W-1:0] rs1_o,
    output logic [REG_W-1:0] rs2_o,
    output logic [REG_W-1:0] rd_o,
    output logic             rd_we_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             is_branch_o,
    output logic             is_store_o,
    output logic             illegal_o
);
    localparam logic [6:0] OPC_R = 7'h33;
    localparam logic [6:0] OPC_I = 7'h13;
    localparam logic [6:0] OPC_S = 7'h23;
    localparam logic [6:0] OPC_B = 7'h63;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

    state_e      r_state;
    logic        r_ready;
    logic        r_valid;
    dec_bundle_t r_out;
    dec_bundle_t r_skid;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_f7_zero;
    logic        w_f7_alt;
    alu_opcode_e w_arith_op;
    logic        w_arith_ill;
    logic        w_ill;
    dec_bundle_t w_dec;
    logic        w_accept;
    logic        w_drain;
    logic        w_enq;

    assign w_opcode  = instr_i[6:0];
    assign w_funct3  = instr_i[14:12];
    assign w_funct7  = instr_i[31:25];
    assign w_f7_zero = (w_funct7 == 7'h00);
    assign w_f7_alt  = (w_funct7 == 7'h20);

    // Shared R/I arithmetic mapping; funct7 only qualifies shifts for I-type.
    always_comb begin
        w_arith_op  = ALU_ADD;
        w_arith_ill = 1'b0;
        case (w_funct3)
            3'b000: begin
                w_arith_op  = (w_opcode == OPC_R && w_f7_alt) ? ALU_SUB : ALU_ADD;
                w_arith_ill = (w_opcode == OPC_R) && !(w_f7_zero || w_f7_alt);
            end
            3'b001: begin
                w_arith_op  = ALU_SLL;
                w_arith_ill = !w_f7_zero;
            end
            3'b101: begin
                w_arith_op  = w_f7_alt ? ALU_SRA : ALU_SRL;
                w_arith_ill = !(w_f7_zero || w_f7_alt);
            end
            default: begin
                case (w_funct3)
                    3'b010:  w_arith_op = ALU_SLT;
                    3'b011:  w_arith_op = ALU_SLTU;
                    3'b100:  w_arith_op = ALU_XOR;
                    3'b110:  w_arith_op = ALU_OR;
                    default: w_arith_op = ALU_AND;
                endcase
                w_arith_ill = (w_opcode == OPC_R) && !w_f7_zero;
            end
        endcase
    end

    always_comb begin
        w_dec        = '0;
        w_dec.alu_op = ALU_ADD;
        w_dec.a_sel  = OP_SEL_REG;
        w_dec.b_sel  = OP_SEL_REG;
        w_dec.pc     = pc_i;
        w_ill        = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_dec.alu_op = w_arith_op;
                w_dec.rs1    = instr_i[19:15];
                w_dec.rs2    = instr_i[24:20];
                w_dec.rd     = instr_i[11:7];
                w_dec.rd_we  = (instr_i[11:7] != 5'd0);
                w_ill        = w_arith_ill;
            end
            OPC_I: begin
                w_dec.alu_op = w_arith_op;
                w_dec.b_sel  = OP_SEL_IMM;
                w_dec.rs1    = instr_i[19:15];
                w_dec.rd     = instr_i[11:7];
                w_dec.rd_we  = (instr_i[11:7] != 5'd0);
                w_dec.imm    = {{20{instr_i[31]}}, instr_i[31:20]};
                w_ill        = w_arith_ill;
            end
            OPC_S: begin
                w_dec.b_sel    = OP_SEL_IMM;
                w_dec.rs1      = instr_i[19:15];
                w_dec.rs2      = instr_i[24:20];
                w_dec.imm      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                w_dec.is_store = 1'b1;
                w_ill          = w_funct3[2] || (w_funct3 == 3'b011);
            end
            OPC_B: begin
                w_dec.rs1       = instr_i[19:15];
                w_dec.rs2       = instr_i[24:20];
                w_dec.imm       = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                   instr_i[30:25], instr_i[11:8], 1'b0};
                w_dec.is_branch = 1'b1;
                case (w_funct3)
                    3'b000:  w_dec.alu_op = ALU_EQ;
                    3'b001:  w_dec.alu_op = ALU_NE;
                    3'b100:  w_dec.alu_op = ALU_SLT;
                    3'b101:  w_dec.alu_op = ALU_GES;
                    3'b110:  w_dec.alu_op = ALU_SLTU;
                    3'b111:  w_dec.alu_op = ALU_GEU;
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal bundles are neutralised: only the PC and the illegal flag survive.
        if (w_ill) begin
            w_dec         = '0;
            w_dec.alu_op  = ALU_ADD;
            w_dec.a_sel   = OP_SEL_REG;
            w_dec.b_sel   = OP_SEL_REG;
            w_dec.pc      = pc_i;
            w_dec.illegal = 1'b1;
        end
    end

    assign w_accept = instr_valid_i && r_ready;
    assign w_drain  = r_valid && dec_ready_i;

`ifdef TOOTHLESS_ILLEGAL_KILL_EN
    logic r_ill_pulse;

    assign w_enq = w_accept && !w_dec.illegal;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_ill_pulse <= 1'b0;
        end else begin
            r_ill_pulse <= w_accept && w_dec.illegal;
        end
    end

    assign illegal_o = r_ill_pulse | r_out.illegal;
`else
    assign w_enq     = w_accept;
    assign illegal_o = r_out.illegal;
`endif

    // Skid-buffer FSM: r_out feeds the ports, r_skid catches the beat that arrives under stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_skid  <= '0;
        end else if (flush_i) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_enq) begin
                        r_out   <= w_dec;
                        r_valid <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_enq && !w_drain) begin
                        r_skid  <= w_dec;
                        r_ready <= 1'b0;
                        r_state <= ST_FULL;
                    end else if (w_enq) begin
                        r_out <= w_dec;
                    end else if (w_drain) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        r_out   <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready_o = r_ready;
    assign dec_valid_o   = r_valid;
    assign alu_op_o      = r_out.alu_op;
    assign op_a_sel_o    = r_out.a_sel;
    assign op_b_sel_o    = r_out.b_sel;
    assign rs1_o         = r_out.rs1;
    assign rs2_o         = r_out.rs2;
    assign rd_o          = r_out.rd;
    assign rd_we_o       = r_out.rd_we;
    assign imm_o         = r_out.imm;
    assign pc_o          = r_out.pc;
    assign is_branch_o   = r_out.is_branch;
    assign is_store_o    = r_out.is_store;
endmodule

// File: tb/tb_toothless_decode.sv
// Directed bench for toothless_decode: decode vectors, backpressure, illegal, flush and reset.
module tb_toothless_decode;
    localparam logic [4:0] E_ADD = 5'd0;
    localparam logic [4:0] E_SUB = 5'd1;
    localparam logic [4:0] E_SRA = 5'd5;
    localparam logic [4:0] E_NE  = 5'd13;
    localparam logic [1:0] S_REG = 2'b00;
    localparam logic [1:0] S_IMM = 2'b10;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, instr_valid_i, instr_ready_o, dec_valid_o, dec_ready_i;
    logic [31:0] instr_i, pc_i, imm_o, pc_o;
    logic [4:0]  alu_op_o, rs1_o, rs2_o, rd_o;
    logic [1:0]  op_a_sel_o, op_b_sel_o;
    logic        rd_we_o, is_branch_o, is_store_o, illegal_o;

    int n_chk  = 0;
    int n_pass = 0;

    toothless_decode dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .alu_op_o      (alu_op_o),
        .op_a_sel_o    (op_a_sel_o),
        .op_b_sel_o    (op_b_sel_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .rd_o          (rd_o),
        .rd_we_o       (rd_we_o),
        .imm_o         (imm_o),
        .pc_o          (pc_o),
        .is_branch_o   (is_branch_o),
        .is_store_o    (is_store_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic chk_bundle(input string tag, input logic [4:0] alu, input logic [1:0] asel,
                              input logic [1:0] bsel, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic [31:0] imm,
                              input logic [31:0] pc, input logic br, input logic st);
        chk({tag, ".valid"}, 32'(dec_valid_o), 32'd1);
        chk({tag, ".alu"},   32'(alu_op_o),    32'(alu));
        chk({tag, ".asel"},  32'(op_a_sel_o),  32'(asel));
        chk({tag, ".bsel"},  32'(op_b_sel_o),  32'(bsel));
        chk({tag, ".rs1"},   32'(rs1_o),       32'(rs1));
        chk({tag, ".rs2"},   32'(rs2_o),       32'(rs2));
        chk({tag, ".rd"},    32'(rd_o),        32'(rd));
        chk({tag, ".we"},    32'(rd_we_o),     32'(we));
        chk({tag, ".imm"},   imm_o,            imm);
        chk({tag, ".pc"},    pc_o,             pc);
        chk({tag, ".br"},    32'(is_branch_o), 32'(br));
        chk({tag, ".st"},    32'(is_store_o),  32'(st));
        chk({tag, ".ill"},   32'(illegal_o),   32'd0);
    endtask

    task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        pc_i          = pc;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b0;
        instr_i = 32'h0; pc_i = 32'h0;
        tick();
        tick();
        chk("rst.ready", 32'(instr_ready_o), 32'd0);
        chk("rst.valid", 32'(dec_valid_o),   32'd0);
        chk("rst.alu",   32'(alu_op_o),      32'd0);
        chk("rst.imm",   imm_o,              32'd0);
        chk("rst.pc",    pc_o,               32'd0);
        chk("rst.ill",   32'(illegal_o),     32'd0);
        rst_i = 1'b0;
        tick();
        chk("post_rst.ready", 32'(instr_ready_o), 32'd1);
        chk("post_rst.valid", 32'(dec_valid_o),   32'd0);

        // Back-to-back decode at full throughput
        dec_ready_i = 1'b1;
        feed(32'h002081B3, 32'h100); tick();
        chk_bundle("add", E_ADD, S_REG, S_REG, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 32'h100, 1'b0, 1'b0);
        feed(32'h402081B3, 32'h104); tick();
        chk_bundle("sub", E_SUB, S_REG, S_REG, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 32'h104, 1'b0, 1'b0);
        feed(32'hFFF00293, 32'h108); tick();
        chk_bundle("addi", E_ADD, S_REG, S_IMM, 5'd0, 5'd0, 5'd5, 1'b1, 32'hFFFFFFFF, 32'h108, 1'b0, 1'b0);
        feed(32'h4033D313, 32'h10C); tick();
        chk_bundle("srai", E_SRA, S_REG, S_IMM, 5'd7, 5'd0, 5'd6, 1'b1, 32'h00000403, 32'h10C, 1'b0, 1'b0);
        feed(32'h0020A423, 32'h110); tick();
        chk_bundle("sw", E_ADD, S_REG, S_IMM, 5'd1, 5'd2, 5'd0, 1'b0, 32'd8, 32'h110, 1'b0, 1'b1);
        feed(32'h00209863, 32'h114); tick();
        chk_bundle("bne", E_NE, S_REG, S_REG, 5'd1, 5'd2, 5'd0, 1'b0, 32'd16, 32'h114, 1'b1, 1'b0);
        feed(32'h00208033, 32'h118); tick();
        chk("add_x0.rd", 32'(rd_o),    32'd0);
        chk("add_x0.we", 32'(rd_we_o), 32'd0);
        instr_valid_i = 1'b0; tick();
        chk("drain.valid", 32'(dec_valid_o), 32'd0);

        // Backpressure: third instruction is refused while full
        dec_ready_i = 1'b0;
        feed(32'h002081B3, 32'h200); tick();
        chk("bp1.valid", 32'(dec_valid_o),   32'd1);
        chk("bp1.ready", 32'(instr_ready_o), 32'd1);
        feed(32'h402081B3, 32'h204); tick();
        chk("bp2.ready", 32'(instr_ready_o), 32'd0);
        chk("bp2.pc",    pc_o,               32'h200);
        feed(32'hFFF00293, 32'h208); tick();
        chk("bp3.ready", 32'(instr_ready_o), 32'd0);
        chk("bp3.pc",    pc_o,               32'h200);
        chk("bp3.alu",   32'(alu_op_o),      32'(E_ADD));
        instr_valid_i = 1'b0; dec_ready_i = 1'b1; tick();
        chk("bp_rel1.pc",    pc_o,               32'h204);
        chk("bp_rel1.alu",   32'(alu_op_o),      32'(E_SUB));
        chk("bp_rel1.valid", 32'(dec_valid_o),   32'd1);
        chk("bp_rel1.ready", 32'(instr_ready_o), 32'd1);
        tick();
        chk("bp_rel2.valid", 32'(dec_valid_o), 32'd0);

        // Illegal instruction
        feed(32'hFFFFFFFF, 32'h300); tick();
        instr_valid_i = 1'b0;
`ifdef TOOTHLESS_ILLEGAL_KILL_EN
        chk("ill.valid", 32'(dec_valid_o), 32'd0);
        chk("ill.pulse", 32'(illegal_o),   32'd1);
        tick();
        chk("ill.pulse_end", 32'(illegal_o),   32'd0);
        chk("ill.valid2",    32'(dec_valid_o), 32'd0);
`else
        chk("ill.valid", 32'(dec_valid_o), 32'd1);
        chk("ill.flag",  32'(illegal_o),   32'd1);
        chk("ill.we",    32'(rd_we_o),     32'd0);
        chk("ill.alu",   32'(alu_op_o),    32'(E_ADD));
        chk("ill.pc",    pc_o,             32'h300);
        tick();
        chk("ill.valid2", 32'(dec_valid_o), 32'd0);
`endif

        // Flush while full, with upstream still presenting
        dec_ready_i = 1'b0;
        feed(32'h002081B3, 32'h400); tick();
        feed(32'h402081B3, 32'h404); tick();
        chk("fl_full.ready", 32'(instr_ready_o), 32'd0);
        flush_i = 1'b1; feed(32'hFFF00293, 32'h408); tick();
        chk("fl_full.valid", 32'(dec_valid_o),   32'd0);
        chk("fl_full.ready2", 32'(instr_ready_o), 32'd1);
        flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b1; tick();
        chk("fl_full.none", 32'(dec_valid_o), 32'd0);

        // Flush in ONE with a real handshake in the same cycle
        dec_ready_i = 1'b0;
        feed(32'h002081B3, 32'h500); tick();
        chk("fl_one.valid0", 32'(dec_valid_o), 32'd1);
        flush_i = 1'b1; feed(32'h402081B3, 32'h504); tick();
        chk("fl_one.valid", 32'(dec_valid_o),   32'd0);
        chk("fl_one.ready", 32'(instr_ready_o), 32'd1);
        flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b1; tick();
        chk("fl_one.none", 32'(dec_valid_o), 32'd0);

        // Reset mid-stream from FULL
        dec_ready_i = 1'b0;
        feed(32'h002081B3, 32'h600); tick();
        feed(32'h402081B3, 32'h604); tick();
        rst_i = 1'b1; flush_i = 1'b1; feed(32'hFFF00293, 32'h608); tick();
        chk("rst2.valid", 32'(dec_valid_o),   32'd0);
        chk("rst2.ready", 32'(instr_ready_o), 32'd0);
        chk("rst2.pc",    pc_o,               32'd0);
        rst_i = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b1; tick();
        chk("rst2.ready2", 32'(instr_ready_o), 32'd1);
        chk("rst2.none",   32'(dec_valid_o),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
